fp_writeback_arbiter: RTL and testbench

//   Write-side front end of the 32-entry FP register file. Merges FPU results and FP

---
 rtl/fp_writeback_arbiter.sv | 119 +++++++++++
 tb/tb_fp_writeback_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_writeback_arbiter.sv
// Write-side front end of the FP register file: round-robin merge of FPU and load results
// into one registered write port, plus a per-register busy scoreboard. Optional macro: FP_WB_FWD_EN.
module fp_writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                       in_Clk,
    input  logic                       in_Rst_N,
    input  logic                       in_fpu_Valid,
    input  logic [ADDR_WIDTH-1:0]      in_fpu_Addr,
    input  logic [DATA_WIDTH-1:0]      in_fpu_Data,
    output logic                       out_fpu_Ready,
    input  logic                       in_ld_Valid,
    input  logic [ADDR_WIDTH-1:0]      in_ld_Addr,
    input  logic [DATA_WIDTH-1:0]      in_ld_Data,
    output logic                       out_ld_Ready,
    input  logic                       in_issue_En,
    input  logic [ADDR_WIDTH-1:0]      in_issue_Addr,
    output logic                       out_wr_En,
    output logic [ADDR_WIDTH-1:0]      out_wr_Addr,
    output logic [DATA_WIDTH-1:0]      out_wr_Data,
`ifdef FP_WB_FWD_EN
    input  logic [ADDR_WIDTH-1:0]      in_addr_A,
    input  logic [ADDR_WIDTH-1:0]      in_addr_B,
    output logic                       out_fwd_Hit_A,
    output logic                       out_fwd_Hit_B,
    output logic [DATA_WIDTH-1:0]      out_fwd_Data_A,
    output logic [DATA_WIDTH-1:0]      out_fwd_Data_B,
`endif
    output logic [2**ADDR_WIDTH-1:0]   out_busy,
    output logic                       out_err
);
    localparam int NREG = 2**ADDR_WIDTH;

    typedef enum logic {SRC_FPU = 1'b0, SRC_LD = 1'b1} src_e;

    src_e                  rr_ptr;
    logic                  grant_fpu;
    logic                  grant_ld;
    logic                  accept_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] data_p0;
    logic [NREG-1:0]       busy;
    logic [NREG-1:0]       busy_nxt;
    logic                  err_issue;
    logic                  err_accept;
    logic                  err_q;
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [DATA_WIDTH-1:0] data_p1;

    // Stage p0: arbitration and acceptance, combinational from the valid inputs
    always_comb begin
        grant_fpu = in_fpu_Valid && (!in_ld_Valid || rr_ptr == SRC_FPU);
        grant_ld  = in_ld_Valid  && (!in_fpu_Valid || rr_ptr == SRC_LD);
        accept_p0 = grant_fpu || grant_ld;
        addr_p0   = grant_ld ? in_ld_Addr : in_fpu_Addr;
        data_p0   = grant_ld ? in_ld_Data : in_fpu_Data;
    end

    assign out_fpu_Ready = grant_fpu;
    assign out_ld_Ready  = grant_ld;

    // Clear before set so a same-edge issue of the written register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (accept_p0)
            busy_nxt[addr_p0] = 1'b0;
        if (in_issue_En)
            busy_nxt[in_issue_Addr] = 1'b1;
    end

    always_comb begin
        err_issue  = in_issue_En && busy[in_issue_Addr];
        err_accept = accept_p0 && !busy[addr_p0] &&
                     !(in_issue_En && (in_issue_Addr == addr_p0));
    end

    // Stage p1: registered register-file write, scoreboard and error flag
    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            rr_ptr  <= SRC_FPU;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            busy    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (in_fpu_Valid && in_ld_Valid)
                rr_ptr <= (rr_ptr == SRC_FPU) ? SRC_LD : SRC_FPU;
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
            busy <= busy_nxt;
            if (err_issue || err_accept)
                err_q <= 1'b1;
        end
    end

    assign out_wr_En   = vld_p1;
    assign out_wr_Addr = addr_p1;
    assign out_wr_Data = data_p1;
    assign out_busy    = busy;
    assign out_err     = err_q;

`ifdef FP_WB_FWD_EN
    always_comb begin
        out_fwd_Hit_A  = vld_p1 && (addr_p1 == in_addr_A);
        out_fwd_Hit_B  = vld_p1 && (addr_p1 == in_addr_B);
        out_fwd_Data_A = data_p1;
        out_fwd_Data_B = data_p1;
    end
`else
    // No bypass: operand fetch waits for out_busy to clear.
`endif

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Directed bench for fp_writeback_arbiter: reset, single writes, contention,
// scoreboard set/clear ordering, error flag and sustained back-to-back writes.
module tb_fp_writeback_arbiter;
    logic        in_Clk = 1'b0;
    logic        in_Rst_N;
    logic        in_fpu_Valid;
    logic [4:0]  in_fpu_Addr;
    logic [31:0] in_fpu_Data;
    logic        out_fpu_Ready;
    logic        in_ld_Valid;
    logic [4:0]  in_ld_Addr;
    logic [31:0] in_ld_Data;
    logic        out_ld_Ready;
    logic        in_issue_En;
    logic [4:0]  in_issue_Addr;
    logic        out_wr_En;
    logic [4:0]  out_wr_Addr;
    logic [31:0] out_wr_Data;
    logic [31:0] out_busy;
    logic        out_err;
`ifdef FP_WB_FWD_EN
    logic [4:0]  in_addr_A;
    logic [4:0]  in_addr_B;
    logic        out_fwd_Hit_A;
    logic        out_fwd_Hit_B;
    logic [31:0] out_fwd_Data_A;
    logic [31:0] out_fwd_Data_B;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fp_writeback_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .in_Clk        (in_Clk),
        .in_Rst_N      (in_Rst_N),
        .in_fpu_Valid  (in_fpu_Valid),
        .in_fpu_Addr   (in_fpu_Addr),
        .in_fpu_Data   (in_fpu_Data),
        .out_fpu_Ready (out_fpu_Ready),
        .in_ld_Valid   (in_ld_Valid),
        .in_ld_Addr    (in_ld_Addr),
        .in_ld_Data    (in_ld_Data),
        .out_ld_Ready  (out_ld_Ready),
        .in_issue_En   (in_issue_En),
        .in_issue_Addr (in_issue_Addr),
        .out_wr_En     (out_wr_En),
        .out_wr_Addr   (out_wr_Addr),
        .out_wr_Data   (out_wr_Data),
`ifdef FP_WB_FWD_EN
        .in_addr_A     (in_addr_A),
        .in_addr_B     (in_addr_B),
        .out_fwd_Hit_A (out_fwd_Hit_A),
        .out_fwd_Hit_B (out_fwd_Hit_B),
        .out_fwd_Data_A(out_fwd_Data_A),
        .out_fwd_Data_B(out_fwd_Data_B),
`endif
        .out_busy      (out_busy),
        .out_err       (out_err)
    );

    always #5 in_Clk = ~in_Clk;

    // Advance to 1 time unit after the next rising edge; inputs change and outputs are read there.
    task automatic tick();
        @(posedge in_Clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_fpu_Valid  = 1'b0;
        in_ld_Valid   = 1'b0;
        in_issue_En   = 1'b0;
    endtask

    task automatic do_reset();
        in_Rst_N = 1'b0;
        idle_inputs();
        tick();
        tick();
        in_Rst_N = 1'b1;
    endtask

    task automatic test_reset();
        in_fpu_Addr = '0; in_fpu_Data = '0;
        in_ld_Addr = '0; in_ld_Data = '0;
        in_issue_Addr = '0;
`ifdef FP_WB_FWD_EN
        in_addr_A = '0; in_addr_B = '0;
`endif
        do_reset();
        n_cmp++; if (out_wr_En !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", out_wr_En); end
        n_cmp++; if (out_wr_Addr !== 5'd0 || out_wr_Data !== 32'd0) begin n_bad++; $display("FAIL reset_wr_addr_data: got %h/%h want 0/0", out_wr_Addr, out_wr_Data); end
        n_cmp++; if (out_busy !== 32'd0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", out_busy); end
        n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", out_err); end
        n_cmp++; if (out_fpu_Ready !== 1'b0 || out_ld_Ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_idle: got %b%b want 00", out_fpu_Ready, out_ld_Ready); end
    endtask

    task automatic test_single_write();
        in_issue_En = 1'b1; in_issue_Addr = 5'd3;
        tick();
        in_issue_En = 1'b0;
        n_cmp++; if (out_busy !== 32'h0000_0008) begin n_bad++; $display("FAIL single_busy_set: got %h want 00000008", out_busy); end
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd3; in_fpu_Data = 32'h3F80_0000;
        #1;
        n_cmp++; if (out_fpu_Ready !== 1'b1 || out_ld_Ready !== 1'b0) begin n_bad++; $display("FAIL single_ready: got %b%b want 10", out_fpu_Ready, out_ld_Ready); end
        n_cmp++; if (out_wr_En !== 1'b0) begin n_bad++; $display("FAIL single_no_early_write: got %b want 0", out_wr_En); end
        tick();
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd3 || out_wr_Data !== 32'h3F80_0000) begin n_bad++; $display("FAIL single_write: got %b/%h/%h want 1/03/3f800000", out_wr_En, out_wr_Addr, out_wr_Data); end
        n_cmp++; if (out_busy !== 32'd0) begin n_bad++; $display("FAIL single_busy_clear: got %h want 0", out_busy); end
        tick();
        n_cmp++; if (out_wr_En !== 1'b0 || out_wr_Addr !== 5'd3 || out_wr_Data !== 32'h3F80_0000) begin n_bad++; $display("FAIL single_hold: got %b/%h/%h want 0/03/3f800000", out_wr_En, out_wr_Addr, out_wr_Data); end
        n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", out_err); end
    endtask

    task automatic test_contest();
        in_issue_En = 1'b1; in_issue_Addr = 5'd1;
        tick();
        in_issue_Addr = 5'd2;
        tick();
        in_issue_En = 1'b0;
        n_cmp++; if (out_busy !== 32'h0000_0006) begin n_bad++; $display("FAIL contest_busy: got %h want 00000006", out_busy); end
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd1; in_fpu_Data = 32'h1111_2222;
        in_ld_Valid  = 1'b1; in_ld_Addr  = 5'd2; in_ld_Data  = 32'h3333_4444;
        #1;
        n_cmp++; if (out_fpu_Ready !== 1'b1 || out_ld_Ready !== 1'b0) begin n_bad++; $display("FAIL contest_first_grant: got %b%b want 10", out_fpu_Ready, out_ld_Ready); end
        tick();
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd1 || out_wr_Data !== 32'h1111_2222) begin n_bad++; $display("FAIL contest_write_fpu: got %b/%h/%h want 1/01/11112222", out_wr_En, out_wr_Addr, out_wr_Data); end
        n_cmp++; if (out_busy !== 32'h0000_0004) begin n_bad++; $display("FAIL contest_busy_after_fpu: got %h want 00000004", out_busy); end
        #1;
        n_cmp++; if (out_ld_Ready !== 1'b1 || out_fpu_Ready !== 1'b0) begin n_bad++; $display("FAIL contest_ld_grant: got %b%b want 01", out_fpu_Ready, out_ld_Ready); end
        tick();
        in_ld_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd2 || out_wr_Data !== 32'h3333_4444) begin n_bad++; $display("FAIL contest_write_ld: got %b/%h/%h want 1/02/33334444", out_wr_En, out_wr_Addr, out_wr_Data); end
        n_cmp++; if (out_busy !== 32'd0) begin n_bad++; $display("FAIL contest_busy_clear: got %h want 0", out_busy); end
        // The pointer flipped after the contested FPU grant; the uncontested LD grant left it on LD.
        in_issue_En = 1'b1; in_issue_Addr = 5'd10;
        tick();
        in_issue_Addr = 5'd11;
        tick();
        in_issue_En = 1'b0;
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd10; in_fpu_Data = 32'hAAAA_0010;
        in_ld_Valid  = 1'b1; in_ld_Addr  = 5'd11; in_ld_Data  = 32'hBBBB_0011;
        #1;
        n_cmp++; if (out_fpu_Ready !== 1'b0 || out_ld_Ready !== 1'b1) begin n_bad++; $display("FAIL contest_second_favours_ld: got %b%b want 01", out_fpu_Ready, out_ld_Ready); end
        tick();
        in_ld_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd11 || out_wr_Data !== 32'hBBBB_0011) begin n_bad++; $display("FAIL contest_write_11: got %b/%h/%h want 1/0b/bbbb0011", out_wr_En, out_wr_Addr, out_wr_Data); end
        tick();
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd10 || out_wr_Data !== 32'hAAAA_0010) begin n_bad++; $display("FAIL contest_write_10: got %b/%h/%h want 1/0a/aaaa0010", out_wr_En, out_wr_Addr, out_wr_Data); end
        tick();
        n_cmp++; if (out_busy !== 32'd0 || out_err !== 1'b0) begin n_bad++; $display("FAIL contest_end_state: got busy %h err %b want 0/0", out_busy, out_err); end
        // Pointer is back on FPU after the LD-won contest.
        in_issue_En = 1'b1; in_issue_Addr = 5'd20;
        tick();
        in_issue_Addr = 5'd21;
        tick();
        in_issue_En = 1'b0;
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd20; in_fpu_Data = 32'h0000_0020;
        in_ld_Valid  = 1'b1; in_ld_Addr  = 5'd21; in_ld_Data  = 32'h0000_0021;
        #1;
        n_cmp++; if (out_fpu_Ready !== 1'b1 || out_ld_Ready !== 1'b0) begin n_bad++; $display("FAIL contest_third_favours_fpu: got %b%b want 10", out_fpu_Ready, out_ld_Ready); end
        tick();
        in_fpu_Valid = 1'b0;
        tick();
        in_ld_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd21) begin n_bad++; $display("FAIL contest_write_21: got %b/%h want 1/15", out_wr_En, out_wr_Addr); end
        tick();
    endtask

    task automatic test_set_wins();
        in_issue_En  = 1'b1; in_issue_Addr = 5'd5;
        in_fpu_Valid = 1'b1; in_fpu_Addr   = 5'd5; in_fpu_Data = 32'h5555_0005;
        #1;
        n_cmp++; if (out_fpu_Ready !== 1'b1) begin n_bad++; $display("FAIL setwins_ready: got %b want 1", out_fpu_Ready); end
        tick();
        in_issue_En = 1'b0;
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_busy !== 32'h0000_0020) begin n_bad++; $display("FAIL setwins_busy: got %h want 00000020", out_busy); end
        n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL setwins_err: got %b want 0", out_err); end
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd5) begin n_bad++; $display("FAIL setwins_write: got %b/%h want 1/05", out_wr_En, out_wr_Addr); end
        in_ld_Valid = 1'b1; in_ld_Addr = 5'd5; in_ld_Data = 32'h5555_0006;
        tick();
        in_ld_Valid = 1'b0;
        n_cmp++; if (out_busy !== 32'd0 || out_err !== 1'b0) begin n_bad++; $display("FAIL setwins_clear: got busy %h err %b want 0/0", out_busy, out_err); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0] regs [4];
        regs = '{5'd12, 5'd13, 5'd14, 5'd0};
        // Issue and write overlap: each cycle issues the next register while writing the previous one.
        in_issue_En = 1'b1; in_issue_Addr = regs[0];
        tick();
        for (int i = 0; i < 4; i++) begin
            in_fpu_Valid = 1'b1; in_fpu_Addr = regs[i]; in_fpu_Data = 32'hC0DE_0000 + 32'(i);
            if (i < 3) begin in_issue_En = 1'b1; in_issue_Addr = regs[i+1]; end
            else in_issue_En = 1'b0;
            tick();
            n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== regs[i] || out_wr_Data !== 32'hC0DE_0000 + 32'(i)) begin n_bad++; $display("FAIL b2b_write%0d: got %b/%h/%h want 1/%h/%h", i, out_wr_En, out_wr_Addr, out_wr_Data, regs[i], 32'hC0DE_0000 + 32'(i)); end
        end
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_busy !== 32'd0 || out_err !== 1'b0) begin n_bad++; $display("FAIL b2b_end_state: got busy %h err %b want 0/0", out_busy, out_err); end
        tick();
        n_cmp++; if (out_wr_En !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", out_wr_En); end
    endtask

    task automatic test_errors();
        in_issue_En = 1'b1; in_issue_Addr = 5'd7;
        tick();
        n_cmp++; if (out_err !== 1'b0) begin n_bad++; $display("FAIL err_first_issue: got %b want 0", out_err); end
        tick();
        in_issue_En = 1'b0;
        n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL err_double_issue: got %b want 1", out_err); end
        tick();
        tick();
        n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", out_err); end
        do_reset();
        n_cmp++; if (out_err !== 1'b0 || out_busy !== 32'd0) begin n_bad++; $display("FAIL err_reset_clears: got err %b busy %h want 0/0", out_err, out_busy); end
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd9; in_fpu_Data = 32'h9999_0009;
        tick();
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_err !== 1'b1) begin n_bad++; $display("FAIL err_write_not_busy: got %b want 1", out_err); end
        n_cmp++; if (out_wr_En !== 1'b1 || out_wr_Addr !== 5'd9 || out_wr_Data !== 32'h9999_0009) begin n_bad++; $display("FAIL err_datapath_unaffected: got %b/%h/%h want 1/09/99990009", out_wr_En, out_wr_Addr, out_wr_Data); end
        tick();
    endtask

    task automatic test_reset_mid_accept();
        in_issue_En = 1'b1; in_issue_Addr = 5'd6;
        tick();
        in_issue_En = 1'b0;
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd6; in_fpu_Data = 32'h6666_0006;
        #2;
        in_Rst_N = 1'b0;
        #1;
        n_cmp++; if (out_err !== 1'b0 || out_busy !== 32'd0) begin n_bad++; $display("FAIL rst_async: got err %b busy %h want 0/0", out_err, out_busy); end
        tick();
        in_Rst_N = 1'b1;
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_wr_En !== 1'b0 || out_busy !== 32'd0 || out_err !== 1'b0) begin n_bad++; $display("FAIL rst_mid_accept: got en %b busy %h err %b want 0/0/0", out_wr_En, out_busy, out_err); end
        tick();
        n_cmp++; if (out_wr_En !== 1'b0) begin n_bad++; $display("FAIL rst_no_late_write: got %b want 0", out_wr_En); end
    endtask

`ifdef FP_WB_FWD_EN
    task automatic test_forward();
        in_issue_En = 1'b1; in_issue_Addr = 5'd4;
        tick();
        in_issue_En = 1'b0;
        in_fpu_Valid = 1'b1; in_fpu_Addr = 5'd4; in_fpu_Data = 32'h4049_0FDB;
        in_addr_A = 5'd4; in_addr_B = 5'd8;
        tick();
        in_fpu_Valid = 1'b0;
        n_cmp++; if (out_fwd_Hit_A !== 1'b1 || out_fwd_Data_A !== 32'h4049_0FDB) begin n_bad++; $display("FAIL fwd_hit_a: got %b/%h want 1/40490fdb", out_fwd_Hit_A, out_fwd_Data_A); end
        n_cmp++; if (out_fwd_Hit_B !== 1'b0) begin n_bad++; $display("FAIL fwd_miss_b: got %b want 0", out_fwd_Hit_B); end
        tick();
        n_cmp++; if (out_fwd_Hit_A !== 1'b0) begin n_bad++; $display("FAIL fwd_no_write: got %b want 0", out_fwd_Hit_A); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_contest();
        test_set_wins();
        test_back_to_back();
        test_errors();
        test_reset_mid_accept();
`ifdef FP_WB_FWD_EN
        test_forward();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
